chip8_framebuffer_server: RTL and testbench
===========================================

Name: chip8_framebuffer_server

Overview:
- Owns the 64x32 one-bit Chip-8 display memory.
- Serves pixel reads to the VGA emulator: it is the responder for fb_request_addr / fb_pixel_data.
- Executes CPU display commands: CLS (clear the screen) and DXYN (XOR a sprite, detect collision).
- Sits between the CPU/memory subsystem and the VGA front end. Sprite bytes are fetched over a simple request/valid handshake.

Parameters:
- FB_W, 64, display width in pixels (fixed; x field is 6 bits)
- FB_H, 32, display height in rows (fixed; y field is 5 bits)

Ports:
- clk50  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous, active-low reset
- fb_request_addr  in  11  VGA pixel address, {y[4:0], x[5:0]}
- fb_pixel_data  out  1  pixel value for the address presented one cycle earlier
- clear_start  in  1  one-cycle pulse: clear the whole screen
- draw_start  in  1  one-cycle pulse: draw a sprite
- draw_x  in  6  sprite origin x, sampled on draw_start
- draw_y  in  5  sprite origin y, sampled on draw_start
- draw_n  in  4  sprite height in rows (0..15), sampled on draw_start
- mem_rd_req  out  1  sprite byte request
- mem_row  out  4  sprite row index for the request (the CPU adds I)
- mem_rd_valid  in  1  sprite byte valid
- mem_rd_data  in  8  sprite byte; bit7 is the leftmost pixel
- busy  out  1  a command is in progress
- done  out  1  one-cycle pulse when a command completes
- collision  out  1  VF result of the last draw

Behaviour:
- Storage: 32 rows x 64-bit registers; row r, bit c = pixel (x=c, y=r).
- Reset (async, reset_n=0): all storage 0, state IDLE, every output 0.
- Read port: fb_pixel_data <= row[addr[10:6]][addr[5:0]] on each clk50 edge. Latency is 1 cycle.
  - Reads are never stalled.
  - A row written at edge k is visible to reads sampled at edge k+1.
- States: IDLE, CLEAR, FETCH, WRITE, DONE.
- IDLE:
  - clear_start=1 -> CLEAR with row counter = 0.
  - Else draw_start=1 -> latch x, y, n, clear the collision register, row counter = 0.
    - If n=0 -> DONE (collision stays 0).
    - Else -> FETCH.
  - If both starts arrive together, clear wins and the draw is dropped.
- CLEAR: zero one row per cycle, counter 0..31; after row 31 -> DONE. Takes 32 cycles.
- FETCH: mem_rd_req=1 and mem_row=row counter, held until mem_rd_valid=1.
  - mem_rd_data is captured in that cycle; -> WRITE.
  - mem_rd_valid is ignored when mem_rd_req=0.
- WRITE: target row yr = (y + counter) mod 32.
  - Mask m: for k in 0..7, bit ((x + k) mod 64) = mem_rd_data[7-k]. Horizontal and vertical both wrap.
  - row[yr] <= row[yr] ^ m.
  - collision <= collision | (|(row[yr] & m)).
  - counter+1; if counter+1 == n -> DONE, else -> FETCH.
- DONE: done=1 for one cycle; -> IDLE.
- busy=1 in CLEAR, FETCH, WRITE, DONE; busy=0 in IDLE.
- clear_start / draw_start while busy are ignored (not queued).
- collision holds its value until the next accepted draw_start. CLEAR does not change it.
- Draw latency: n fetches, each (memory wait + 1) cycles, plus n WRITE cycles, plus 1 DONE cycle. With zero-wait memory (valid same cycle as req): 2n+1 cycles from the start edge to done.
- Reset asserted mid-command aborts it immediately. Storage is zeroed, and mem_rd_req drops asynchronously.

Test Plan:
- Reset, then sweep fb_request_addr 0..2047 -> fb_pixel_data=0 everywhere; busy=0, done=0, collision=0.
- Draw x=10, y=5, n=1, byte 0xF0, zero-wait memory -> addrs 330..333 read 1, 334 reads 0; done 3 cycles after start; collision=0.
- Repeat the same draw -> pixels 330..333 back to 0; collision=1.
- Horizontal/vertical wrap: draw x=62, y=31, n=2, bytes 0xFF, 0x81.
  - Row 31, x 62,63,0..5 = 1.
  - Row 0: x=62 and x=5 set, others 0.
  - collision=0.
- Memory stall: hold mem_rd_valid low 5 cycles per row, n=3 -> mem_rd_req stays high through each stall with a stable mem_row; done at 3*6+3+1 cycles after start.
- Fill a pattern, issue clear_start and draw_start in the same cycle -> clear executes; done after 32+1 cycles; all pixels 0; draw_start during busy ignored; collision unchanged.

Source files
------------

// File: rtl/chip8_framebuffer_server.sv
// Purpose: owns the 64x32 one-bit Chip-8 display and executes CLS / DXYN sprite-XOR commands.
// Latency: pixel reads return 1 cycle after the address; draw = n*(mem wait+1) + n + 1 cycles, clear = 33 cycles.
// Backpressure: pixel reads never stall; sprite fetch holds mem_rd_req/mem_row until mem_rd_valid; starts while busy are dropped.
//
// Ports:
//   clk50, reset_n                       clock, async active-low reset
//   fb_request_addr / fb_pixel_data      VGA read port, addr = {y[4:0], x[5:0]}
//   clear_start, draw_start, draw_x/y/n  command pulses and draw operands
//   mem_rd_req, mem_row, mem_rd_valid,
//   mem_rd_data                          sprite byte fetch handshake (bit7 = leftmost pixel)
//   busy, done, collision                command status and VF result
module chip8_framebuffer_server #(
  parameter int FB_W = 64,
  parameter int FB_H = 32
) (
  input  logic        clk50,
  input  logic        reset_n,
  input  logic [10:0] fb_request_addr,
  output logic        fb_pixel_data,
  input  logic        clear_start,
  input  logic        draw_start,
  input  logic [5:0]  draw_x,
  input  logic [4:0]  draw_y,
  input  logic [3:0]  draw_n,
  output logic        mem_rd_req,
  output logic [3:0]  mem_row,
  input  logic        mem_rd_valid,
  input  logic [7:0]  mem_rd_data,
  output logic        busy,
  output logic        done,
  output logic        collision
);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [FB_W-1:0]   fb_mem [FB_H];
  logic [4:0]        row_cnt;
  logic [4:0]        row_nxt;
  logic [5:0]        x_q;
  logic [4:0]        y_q;
  logic [3:0]        n_q;
  logic [7:0]        byte_q;
  logic [4:0]        yr;
  logic [FB_W-1:0]   mask;
  logic              collision_q;

  assign row_nxt   = row_cnt + 5'd1;
  // Target row wraps vertically through the 5-bit add.
  assign yr        = y_q + row_cnt;
  assign mem_row   = row_cnt[3:0];
  assign collision = collision_q;

  // Sprite byte spread across the row; the 6-bit index add gives horizontal wrap.
  always_comb begin
    mask = '0;
    for (int k = 0; k < 8; k++) begin
      mask[x_q + 6'(k)] = byte_q[7-k];
    end
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_rd_req = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (clear_start) begin
          state_d = CLEAR;
        end else if (draw_start) begin
          state_d = (draw_n == 4'd0) ? DONE : FETCH;
        end
      end
      CLEAR: begin
        if (row_cnt == 5'd31) state_d = DONE;
      end
      FETCH: begin
        mem_rd_req = 1'b1;
        if (mem_rd_valid) state_d = WRITE;
      end
      WRITE: begin
        state_d = (row_nxt == {1'b0, n_q}) ? DONE : FETCH;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < FB_H; r++) begin
        fb_mem[r] <= '0;
      end
      fb_pixel_data <= 1'b0;
      row_cnt       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      n_q           <= '0;
      byte_q        <= '0;
      collision_q   <= 1'b0;
    end else begin
      fb_pixel_data <= fb_mem[fb_request_addr[10:6]][fb_request_addr[5:0]];
      case (state_q)
        IDLE: begin
          if (clear_start) begin
            row_cnt <= '0;
          end else if (draw_start) begin
            x_q         <= draw_x;
            y_q         <= draw_y;
            n_q         <= draw_n;
            collision_q <= 1'b0;
            row_cnt     <= '0;
          end
        end
        CLEAR: begin
          fb_mem[row_cnt] <= '0;
          row_cnt         <= row_nxt;
        end
        FETCH: begin
          if (mem_rd_valid) byte_q <= mem_rd_data;
        end
        WRITE: begin
          fb_mem[yr]  <= fb_mem[yr] ^ mask;
          collision_q <= collision_q | (|(fb_mem[yr] & mask));
          row_cnt     <= row_nxt;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_framebuffer_server.sv
// Purpose: directed self-checking bench for chip8_framebuffer_server with a pixel/row scoreboard.
// Latency: pixel expectations are popped one cycle after the address is driven.
// Backpressure: a behavioural sprite memory answers mem_rd_req after a configurable number of wait cycles.
module tb_chip8_framebuffer_server;

  logic        clk50 = 1'b0;
  logic        reset_n;
  logic [10:0] fb_request_addr;
  logic        fb_pixel_data;
  logic        clear_start;
  logic        draw_start;
  logic [5:0]  draw_x;
  logic [4:0]  draw_y;
  logic [3:0]  draw_n;
  logic        mem_rd_req;
  logic [3:0]  mem_row;
  logic        mem_rd_valid;
  logic [7:0]  mem_rd_data;
  logic        busy;
  logic        done;
  logic        collision;

  int          n_assert = 0;
  int          n_fail   = 0;

  logic [63:0] model [32];
  logic        exp_coll;
  logic [7:0]  sprite [16];
  int          wait_cfg;
  int          wait_cnt;
  logic        pix_q [$];
  int          addr_q [$];
  int          row_q [$];

  chip8_framebuffer_server dut (
    .clk50           (clk50),
    .reset_n         (reset_n),
    .fb_request_addr (fb_request_addr),
    .fb_pixel_data   (fb_pixel_data),
    .clear_start     (clear_start),
    .draw_start      (draw_start),
    .draw_x          (draw_x),
    .draw_y          (draw_y),
    .draw_n          (draw_n),
    .mem_rd_req      (mem_rd_req),
    .mem_row         (mem_row),
    .mem_rd_valid    (mem_rd_valid),
    .mem_rd_data     (mem_rd_data),
    .busy            (busy),
    .done            (done),
    .collision       (collision)
  );

  always #10 clk50 = ~clk50;

  // Sprite memory: valid after wait_cfg stalled cycles of an outstanding request.
  always @(posedge clk50) begin
    if (mem_rd_req && !mem_rd_valid) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end
  assign mem_rd_valid = mem_rd_req && (wait_cnt >= wait_cfg);
  assign mem_rd_data  = sprite[mem_row];

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_pix(input int a);
    return model[a / 64][a % 64];
  endfunction

  // Apply one DXYN to the bench's own picture and return the VF it should produce.
  function automatic logic model_draw(input int x, input int y, input int n);
    logic c = 1'b0;
    for (int r = 0; r < n; r++) begin
      for (int k = 0; k < 8; k++) begin
        if (sprite[r][7-k]) begin
          int yy = (y + r) % 32;
          int xx = (x + k) % 64;
          if (model[yy][xx]) c = 1'b1;
          model[yy][xx] = ~model[yy][xx];
        end
      end
    end
    return c;
  endfunction

  task automatic probe(input int a, input logic exp, input string tag);
    @(negedge clk50);
    fb_request_addr = 11'(a);
    pix_q.push_back(exp);
    @(negedge clk50);
    check($sformatf("%s@%0d", tag, a), fb_pixel_data, pix_q.pop_front());
  endtask

  task automatic sweep(input string tag);
    pix_q.delete();
    addr_q.delete();
    for (int a = 0; a < 2048; a++) begin
      @(negedge clk50);
      if (pix_q.size() > 0) begin
        check($sformatf("%s@%0d", tag, addr_q.pop_front()), fb_pixel_data, pix_q.pop_front());
      end
      fb_request_addr = 11'(a);
      addr_q.push_back(a);
      pix_q.push_back(model_pix(a));
    end
    @(negedge clk50);
    check($sformatf("%s@%0d", tag, addr_q.pop_front()), fb_pixel_data, pix_q.pop_front());
  endtask

  task automatic run_cmd(input string tag, input bit clr, input bit drw, input int x, input int y,
                         input int n, input int exp_lat, input int poke_cyc);
    int  cyc;
    bit  seen;
    @(negedge clk50);
    row_q.delete();
    if (clr) begin
      for (int r = 0; r < 32; r++) model[r] = '0;
    end else if (drw) begin
      exp_coll = model_draw(x, y, n);
      for (int r = 0; r < n; r++) row_q.push_back(r);
    end
    clear_start = clr;
    draw_start  = drw;
    draw_x      = 6'(x);
    draw_y      = 5'(y);
    draw_n      = 4'(n);
    @(negedge clk50);
    clear_start = 1'b0;
    draw_start  = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    check({tag, "_busy"}, busy, 1'b1);
    while (!seen && cyc <= 300) begin
      draw_start = (cyc == poke_cyc);
      if (mem_rd_req) begin
        if (row_q.size() > 0) check({tag, "_mem_row"}, mem_row, 4'(row_q[0]));
        else check({tag, "_req_unexpected"}, mem_rd_req, 1'b0);
        if (mem_rd_valid && row_q.size() > 0) void'(row_q.pop_front());
      end
      if (done) begin
        seen = 1'b1;
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_rows_left"}, row_q.size(), 0);
      end else begin
        @(negedge clk50);
        cyc++;
      end
    end
    draw_start = 1'b0;
    if (!seen) check({tag, "_done_timeout"}, done, 1'b1);
    check({tag, "_collision"}, collision, exp_coll);
    @(negedge clk50);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_done"}, done, 1'b0);
  endtask

  initial begin
    reset_n         = 1'b0;
    fb_request_addr = '0;
    clear_start     = 1'b0;
    draw_start      = 1'b0;
    draw_x          = '0;
    draw_y          = '0;
    draw_n          = '0;
    wait_cfg        = 0;
    wait_cnt        = 0;
    exp_coll        = 1'b0;
    for (int r = 0; r < 32; r++) model[r] = '0;
    for (int r = 0; r < 16; r++) sprite[r] = '0;

    // Reset state
    repeat (3) @(negedge clk50);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_collision", collision, 1'b0);
    check("rst_mem_rd_req", mem_rd_req, 1'b0);
    check("rst_pixel", fb_pixel_data, 1'b0);
    reset_n = 1'b1;
    sweep("rst_sweep");

    // Single-row draw, zero-wait memory
    sprite[0] = 8'hF0;
    run_cmd("draw1", 1'b0, 1'b1, 10, 5, 1, 3, 0);
    for (int a = 330; a <= 333; a++) probe(a, 1'b1, "draw1_on");
    probe(334, 1'b0, "draw1_off");
    probe(329, 1'b0, "draw1_off");
    check("draw1_vf", collision, 1'b0);

    // Same draw again erases and collides
    run_cmd("draw2", 1'b0, 1'b1, 10, 5, 1, 3, 0);
    for (int a = 330; a <= 333; a++) probe(a, 1'b0, "draw2_off");
    check("draw2_vf", collision, 1'b1);

    // Horizontal and vertical wrap
    sprite[0] = 8'hFF;
    sprite[1] = 8'h81;
    run_cmd("wrap", 1'b0, 1'b1, 62, 31, 2, 5, 0);
    probe(31*64 + 62, 1'b1, "wrap_r31");
    probe(31*64 + 63, 1'b1, "wrap_r31");
    for (int xx = 0; xx <= 5; xx++) probe(31*64 + xx, 1'b1, "wrap_r31");
    probe(31*64 + 6, 1'b0, "wrap_r31_off");
    probe(62, 1'b1, "wrap_r0");
    probe(5, 1'b1, "wrap_r0");
    probe(63, 1'b0, "wrap_r0_off");
    probe(0, 1'b0, "wrap_r0_off");
    check("wrap_vf", collision, 1'b0);
    sweep("wrap_sweep");

    // Memory stalls of 5 cycles per row
    sprite[0] = 8'h3C;
    sprite[1] = 8'h42;
    sprite[2] = 8'h99;
    wait_cfg  = 5;
    run_cmd("stall", 1'b0, 1'b1, 20, 10, 3, 3*6 + 3 + 1, 0);
    wait_cfg  = 0;
    sweep("stall_sweep");

    // Overlapping redraw to leave VF set before the clear
    run_cmd("redraw", 1'b0, 1'b1, 20, 10, 1, 3, 0);
    check("redraw_vf", collision, 1'b1);

    // Clear and draw together: clear wins, a draw poked mid-clear is dropped, VF kept
    run_cmd("clear", 1'b1, 1'b1, 0, 0, 4, 33, 10);
    repeat (3) begin
      @(negedge clk50);
      check("clear_after_busy", busy, 1'b0);
    end
    check("clear_vf_kept", collision, 1'b1);
    sweep("clear_sweep");

    // Zero-height draw: immediate done, VF cleared
    run_cmd("n0", 1'b0, 1'b1, 3, 3, 0, 1, 0);
    check("n0_vf", collision, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
